ikaopm_dac: RTL

IKAOPM_DAC -- requirements
Module: IKAOPM_dac

---
 rtl/ikaopm_dac_pkg.sv | 37 +++
 rtl/ikaopm_dac_if.sv | 12 +
 rtl/ikaopm_dac_decode.sv | 10 +
 rtl/ikaopm_dac.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/ikaopm_dac_pkg.sv
// Shared constants, state/channel encodings and the float-to-linear helper
// for the YM2151 serial DAC front end.
package IKAOPM_pkg;

  localparam int FRAME_LEN = 16;
  localparam int MANT_LSB  = 3;
  localparam int MANT_W    = 10;
  localparam int EXP_LSB   = 13;
  localparam int EXP_W     = 3;
  localparam int LIN_W     = 16;

  typedef enum logic {
    ST_HUNT = 1'b0,
    ST_LOCK = 1'b1
  } dac_state_t;

  typedef enum logic {
    CH_R = 1'b0,
    CH_L = 1'b1
  } dac_chan_t;

  // Mantissa MSB is an inverted sign (offset binary); exponent 0 means silence.
  function automatic logic signed [LIN_W-1:0] float_to_lin(
    input logic [MANT_W-1:0] m,
    input logic [EXP_W-1:0]  e
  );
    logic signed [LIN_W-1:0] base;
    logic signed [LIN_W-1:0] result;
    base   = {{(LIN_W-MANT_W){~m[MANT_W-1]}}, ~m[MANT_W-1], m[MANT_W-2:0]};
    result = '0;
    if (e != '0) begin
      result = base <<< (e - EXP_W'(1));
    end
    return result;
  endfunction

endpackage

// File: rtl/ikaopm_dac_if.sv
// Link between the framing logic (master) and the shared float decoder (slave).
interface ikaopm_dac_if;
  import IKAOPM_pkg::*;

  logic [MANT_W-1:0]       mant;
  logic [EXP_W-1:0]        expo;
  logic signed [LIN_W-1:0] lin;

  modport master (output mant, output expo, input lin);
  modport slave  (input mant, input expo, output lin);

endinterface

// File: rtl/ikaopm_dac_decode.sv
// Combinational float-to-linear decoder, one instance shared by both channels.
module IKAOPM_dac_decode
  import IKAOPM_pkg::*;
(
  ikaopm_dac_if.slave dac
);

  assign dac.lin = float_to_lin(dac.mant, dac.expo);

endmodule

// File: rtl/ikaopm_dac.sv
// YM2151 serial sound-data receiver: frames LSB-first words on sync pulses,
// decodes them to signed linear samples and reports framing errors.
module ikaopm_dac #(
  parameter int FRAME_LEN = IKAOPM_pkg::FRAME_LEN,
  parameter int ERRCNT_W  = 8
) (
  input  logic                i_EMUCLK,
  input  logic                i_MRST,
  input  logic                i_phi1_NCEN_n,
  input  logic                i_SO,
  input  logic                i_SYNC_R,
  input  logic                i_SYNC_L,
  output logic signed [15:0]  o_R,
  output logic signed [15:0]  o_L,
  output logic                o_R_SAMPLE,
  output logic                o_L_SAMPLE,
  output logic                o_LOCK,
  output logic                o_FRAME_ERR,
  output logic [ERRCNT_W-1:0] o_ERR_CNT
);
  import IKAOPM_pkg::*;

  localparam int               CNT_W    = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic                    cen;
  logic                    sync_one;
  logic                    sync_both;
  dac_chan_t               sync_ch;

  dac_state_t              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [FRAME_LEN-1:0]    sr_q, sr_d;
  dac_chan_t               last_q, last_d;
  logic                    pend_q, pend_d;
  dac_chan_t               pend_ch_q, pend_ch_d;
  logic signed [15:0]      r_q, r_d, l_q, l_d;
  logic                    r_stb_q, r_stb_d, l_stb_q, l_stb_d;
  logic                    err_q, err_d;
  logic [ERRCNT_W-1:0]     errcnt_q, errcnt_d;
  logic                    unused_sr_lsb;

  ikaopm_dac_if dec_if ();

  // The accepted word sits in sr_q until the next enabled edge, which is
  // exactly when it is decoded and committed to the output register.
  assign dec_if.mant   = sr_q[MANT_LSB +: MANT_W];
  assign dec_if.expo   = sr_q[EXP_LSB +: EXP_W];
  assign unused_sr_lsb = sr_q[0];

  IKAOPM_dac_decode u_decode (
    .dac (dec_if)
  );

  assign cen       = ~i_phi1_NCEN_n;
  assign sync_one  = i_SYNC_R ^ i_SYNC_L;
  assign sync_both = i_SYNC_R & i_SYNC_L;
  assign sync_ch   = i_SYNC_L ? CH_L : CH_R;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it
    // unassigned; that is what keeps this block free of inferred latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    sr_d      = sr_q;
    last_d    = last_q;
    pend_d    = pend_q;
    pend_ch_d = pend_ch_q;
    r_d       = r_q;
    l_d       = l_q;
    r_stb_d   = 1'b0;
    l_stb_d   = 1'b0;
    err_d     = 1'b0;
    errcnt_d  = errcnt_q;

    if (cen) begin
      sr_d   = {i_SO, sr_q[FRAME_LEN-1:1]};
      cnt_d  = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
      pend_d = 1'b0;

      if (pend_q) begin
        if (pend_ch_q == CH_R) begin
          r_d     = dec_if.lin;
          r_stb_d = 1'b1;
        end else begin
          l_d     = dec_if.lin;
          l_stb_d = 1'b1;
        end
      end

      if (i_SYNC_R || i_SYNC_L) begin
        cnt_d = '0;
      end

      unique case (state_q)
        ST_HUNT: begin
          if (sync_one) begin
            last_d  = sync_ch;
            state_d = ST_LOCK;
          end
        end
        ST_LOCK: begin
          if (sync_both) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end else if (sync_one) begin
            last_d = sync_ch;
            if (cnt_q == CNT_LAST && sync_ch != last_q) begin
              pend_d    = 1'b1;
              pend_ch_d = sync_ch;
            end else begin
              err_d = 1'b1;
            end
          end else if (cnt_q == CNT_LAST) begin
            err_d   = 1'b1;
            state_d = ST_HUNT;
          end
        end
        default: state_d = ST_HUNT;
      endcase

      if (err_d && errcnt_q != '1) begin
        errcnt_d = errcnt_q + ERRCNT_W'(1);
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      state_q   <= ST_HUNT;
      cnt_q     <= '0;
      sr_q      <= '0;
      last_q    <= CH_R;
      pend_q    <= 1'b0;
      pend_ch_q <= CH_R;
      r_q       <= '0;
      l_q       <= '0;
      r_stb_q   <= 1'b0;
      l_stb_q   <= 1'b0;
      err_q     <= 1'b0;
      errcnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sr_q      <= sr_d;
      last_q    <= last_d;
      pend_q    <= pend_d;
      pend_ch_q <= pend_ch_d;
      r_q       <= r_d;
      l_q       <= l_d;
      r_stb_q   <= r_stb_d;
      l_stb_q   <= l_stb_d;
      err_q     <= err_d;
      errcnt_q  <= errcnt_d;
    end
  end

  assign o_R         = r_q;
  assign o_L         = l_q;
  assign o_R_SAMPLE  = r_stb_q;
  assign o_L_SAMPLE  = l_stb_q;
  assign o_LOCK      = (state_q == ST_LOCK);
  assign o_FRAME_ERR = err_q;
  assign o_ERR_CNT   = errcnt_q;

endmodule
